// File: rtl/line_word_serializer.sv
// Cache-line to word serializer: accepts one WORDS_PER_ENTRY-word line and emits
// its words LSB-first over a valid/ready stream, with zero-bubble line chaining.
module line_word_serializer #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_ENTRY = 16,
  localparam int IDX_W          = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] in_line,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_word,
  output logic [IDX_W-1:0]                      out_index,
  output logic                                  out_first,
  output logic                                  out_last,
  output logic                                  out_zero_line,
  output logic                                  dict_wr
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                state_reg, state_next;
  logic [IDX_W-1:0]                      index_reg, index_next;
  logic                                  zero_reg, zero_next;
  logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] line_reg;
  logic [DATA_WIDTH-1:0]                 words [WORDS_PER_ENTRY];
  logic                                  accept;
  logic                                  last_word;

  for (genvar gi = 0; gi < WORDS_PER_ENTRY; gi++) begin : g_words
    assign words[gi] = line_reg[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign last_word     = (index_reg == IDX_W'(WORDS_PER_ENTRY - 1));
  assign out_valid     = (state_reg == SEND);
  assign out_word      = words[index_reg];
  assign out_index     = index_reg;
  assign out_first     = out_valid && (index_reg == '0);
  assign out_last      = out_valid && last_word;
  assign out_zero_line = out_valid && zero_reg;
  assign dict_wr       = out_valid && out_ready;
  // Ready again during the last handshake so a waiting line follows with no bubble.
  assign in_ready      = (state_reg == IDLE) || (dict_wr && last_word);
  assign accept        = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    zero_next  = zero_reg;
    if (accept) begin
      state_next = SEND;
      index_next = '0;
      zero_next  = (in_line == '0);
    end else if (dict_wr) begin
      if (last_word) begin
        state_next = IDLE;
      end else begin
        index_next = index_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      index_reg <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      zero_reg  <= zero_next;
    end
  end

  // Buffer is deliberately unreset; it is only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_reg <= in_line;
    end
  end

endmodule

// File: doc/line_word_serializer.md
LINE_WORD_SERIALIZER -- requirements
Module: line_word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per word.
REQ-002 SHALL have parameter WORDS_PER_ENTRY, default 16, words per 64-byte line; power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream line valid.
REQ-006 SHALL have port in_ready  output  1  line accepted when in_valid && in_ready.
REQ-007 SHALL have port in_line  input  WORDS_PER_ENTRY*DATA_WIDTH  cache line; word k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port out_valid  output  1  out_word valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts word when out_valid && out_ready.
REQ-010 SHALL have port out_word  output  DATA_WIDTH  current word.
REQ-011 SHALL have port out_index  output  $clog2(WORDS_PER_ENTRY)  index of out_word within line.
REQ-012 SHALL have port out_first / out_last  output  1 each  out_index == 0 / == WORDS_PER_ENTRY-1, gated by out_valid.
REQ-013 SHALL have port out_zero_line  output  1  current line is all zeros, gated by out_valid.
REQ-014 SHALL have port dict_wr  output  1  word-write strobe to dictionary stage = out_valid && out_ready.

Function
REQ-015 SHALL implement FSM with states IDLE and SEND.
REQ-016 SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
REQ-017 SHALL on accept capture in_line into line buffer, compute zero flag (in_line == 0) into register, set word index to 0, enter SEND.
REQ-018 SHALL ignore in_line/in_valid while in_ready is 0; buffer unchanged.
REQ-019 SHALL drive out_valid = (state==SEND); out_word = buffer word [index], combinational from registers only.
REQ-020 SHALL emit words in order 0,1,...,WORDS_PER_ENTRY-1 (LSB word first), one per handshake.
REQ-021 SHALL hold out_word, out_index, flags stable while out_valid && !out_ready.
REQ-022 SHALL increment index by 1 on each non-last handshake; no wrap beyond WORDS_PER_ENTRY-1.
REQ-023 SHALL on last-word handshake: if in_valid same cycle, load new line, index 0, stay SEND (zero-bubble back-to-back); else go IDLE.
REQ-024 SHALL deliver first word of an accepted line on the cycle after acceptance (latency 1).
REQ-025 SHALL sustain throughput of 1 word/cycle with out_ready held high, WORDS_PER_ENTRY cycles per line.
REQ-026 SHALL never drop, duplicate, or reorder a word under any out_ready pattern.

Reset
REQ-027 SHALL, while reset_n==0, force state IDLE, index 0, zero flag 0, out_valid 0, dict_wr 0, out_first/out_last/out_zero_line 0; in_ready is 1 after release.
REQ-028 SHALL discard a partially sent line on reset; downstream dictionary stage is reset in the same cycle so its write index realigns to 0.
REQ-029 SHALL leave line buffer contents unreset (not observable while out_valid==0).

Verification
REQ-030 SHALL pass: line of words 0x00000000..0x0000000F, out_ready=1 -> 16 consecutive words 0x0..0xF, out_first on cycle 1, out_last on cycle 16, dict_wr 16 cycles.
REQ-031 SHALL pass: two lines presented back-to-back, out_ready=1 -> 32 consecutive dict_wr cycles, no gap, in_ready high on second line's accept cycle.
REQ-032 SHALL pass: out_ready toggling 1,0,0,1 repeating -> every word delivered once, in order, outputs stable during stalls, in_ready 0 until last handshake.
REQ-033 SHALL pass: all-zero line -> out_zero_line=1 for all 16 words; next line with single bit set -> out_zero_line=0.
REQ-034 SHALL pass: reset_n asserted after word 7 -> out_valid 0 immediately (asynchronous); after release, new line starts at out_index 0.
REQ-035 SHALL pass: in_line changed while in_ready=0 -> emitted words match originally accepted line.
